// File: rtl/matrix_pkg.sv
// matrix_pkg: shared op codes, sequencer state encoding and default widths for the matrix transfer sequencer
package matrix_pkg;
  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ = 1'b1;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DIM_W = 10;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;
endpackage

// File: rtl/matrix_rd_fifo.sv
// matrix_rd_fifo: sync FIFO (push_i/wdata_i in, pop_i/rdata_o out, count_o occupancy), async active-high rst
module matrix_rd_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(push_i);
      rptr_q <= rptr_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/matrix_xfer_seq.sv
// matrix_xfer_seq: turns one matrix read/write command plus wr/rd valid-ready streams into we/re strobes for matrix_ctrl, with credit-buffered read data
module matrix_xfer_seq
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W = DEF_DIM_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              we,
  output logic              re,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [DIM_W-1:0] rows_q, cols_q, row_q, col_q, row_d, col_d;
  logic [RD_LAT-1:0] vld_q, lst_q;
  logic [CW-1:0] occ, inflight;
  logic [DATA_W:0] head;
  logic done_q, done_d, pop, accept, is_last, adv;
  assign is_last = row_q == rows_q && col_q == cols_q;
  assign rd_valid = occ != '0;
  assign pop = rd_valid && rd_ready;
  assign rd_data = rd_valid ? head[DATA_W-1:0] : '0;
  assign rd_last = rd_valid && head[DATA_W];
  assign ram_wdata = state_q == WRITE ? wr_data : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign accept = cmd_valid && cmd_ready;
  assign adv = we || re;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
  end
  always_comb begin
    state_d = state_q;
    cmd_ready = 1'b0;
    wr_ready = 1'b0;
    we = 1'b0;
    re = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_op == OP_READ ? READ : WRITE;
      end
      WRITE: begin
        wr_ready = 1'b1;
        we = wr_valid;
        done_d = wr_valid && is_last;
        state_d = done_d ? IDLE : WRITE;
      end
      READ: begin
        re = occ + inflight < CW'(FIFO_DEPTH);
        state_d = re && is_last ? DRAIN : READ;
      end
      DRAIN: begin
        done_d = pop && rd_last;
        state_d = done_d ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      col_d = col_q == cols_q ? '0 : col_q + 1'b1;
      row_d = col_q != cols_q ? row_q : is_last ? '0 : row_q + 1'b1;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rows_q <= '0;
      cols_q <= '0;
      row_q <= '0;
      col_q <= '0;
      vld_q <= '0;
      lst_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q <= accept ? cfg_rows : rows_q;
      cols_q <= accept ? cfg_cols : cols_q;
      row_q <= row_d;
      col_q <= col_d;
      done_q <= done_d;
      vld_q[0] <= re;
      lst_q[0] <= re && is_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end
  matrix_rd_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push_i(vld_q[RD_LAT-1]),
    .wdata_i({lst_q[RD_LAT-1], ram_rdata}),
    .pop_i(pop),
    .rdata_o(head),
    .count_o(occ)
  );
endmodule

// File: doc/matrix_xfer_seq.md
# matrix_xfer_seq

Transfer sequencer that sits directly upstream of `matrix_ctrl`. It accepts one read or write command for the whole configured matrix and converts valid/ready element streams into the single-cycle `we`/`re` strobes that advance `matrix_ctrl`'s internal 2-D counters. Read data returning from the RAM bank is buffered in a credit-controlled FIFO, so the host may stall without losing data. The sequencer mirrors the row/column walk, so it knows the final element and leaves `matrix_ctrl`'s counters wrapped back to (0,0).

## Interface
- `DATA_W`, default 16: element width.
- `DIM_W`, default 10: row/column index width; matches `max_row_count`/`max_col_count`.
- `RD_LAT`, default 1: RAM read latency in cycles, from `re` to `ram_rdata` valid.
- `FIFO_DEPTH`, default 4: read buffer entries. Must be ≥ `RD_LAT`+1 and a power of 2.

Ports:
- `CLK` in 1: clock; all logic on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `cfg_rows` in DIM_W: last row index, the same value driven to `matrix_ctrl.max_row_count`.
- `cfg_cols` in DIM_W: last column index.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd_op` in 1: command handshake; `cmd_op` 0 = write, 1 = read.
- `wr_data` in DATA_W, `wr_valid` in 1, `wr_ready` out 1: write element stream.
- `rd_data` out DATA_W, `rd_valid` out 1, `rd_ready` in 1, `rd_last` out 1: read element stream.
- `we` out 1, `re` out 1: strobes to `matrix_ctrl`.
- `ram_wdata` out DATA_W: write data to the RAM bank.
- `ram_rdata` in DATA_W: muxed RAM read data, valid `RD_LAT` cycles after `re`.
- `busy` out 1, `done` out 1: status; `done` is a one-cycle pulse.

## Operation
- **States:**
  - IDLE: `cmd_ready`=1.
  - WRITE.
  - READ: issuing `re`.
  - DRAIN: all `re` issued, FIFO not yet empty.
- **Command accept:** on `cmd_valid && cmd_ready`, latch `cfg_rows`, `cfg_cols` and `cmd_op`, clear the row/column counters, then go to WRITE (op 0) or READ (op 1).
- **Element count:** (cfg_rows+1)·(cfg_cols+1). Column counts 0..cfg_cols, then wraps to 0 and increments row. rows=cols=0 means one element.
- **WRITE:**
  - `wr_ready`=1.
  - `we` = `wr_valid`, combinational; `ram_wdata` = `wr_data`.
  - The counter advances on each handshake.
  - The handshake at (cfg_rows, cfg_cols) moves the FSM to IDLE.
- **READ:**
  - `re`=1 when credit > 0, where credit = FIFO_DEPTH − occupancy − in-flight.
  - `RD_LAT`-deep valid shift register tracks in-flight reads and pushes `ram_rdata` into the FIFO.
  - The `re` at the final element moves the FSM to DRAIN.
- **DRAIN:** leave to IDLE when the FIFO is empty and nothing is in flight.
- **Read output:**
  - `rd_valid` = FIFO non-empty; pop on `rd_valid && rd_ready`.
  - `rd_last`=1 on the head entry that is the final element of the command (a last tag is stored per entry).
- **Strobes:** `we` and `re` are never both 1.
- **Inputs ignored:** `wr_valid` outside WRITE, `cmd_valid` outside IDLE, and changes to `cfg_*` mid-command.
- **Status:** `busy` = state≠IDLE.

## Timing
- **Reset values:** state IDLE; `cmd_ready`=1; all other outputs 0; FIFO empty; counters 0.
- **Command:** accepted in cycle t; first `we`/`re` possible at t+1.
- **Write:** `we` is in the same cycle as the `wr_valid` handshake, with zero added latency.
- **Read:**
  - `re` at cycle t gives data in the FIFO at t+RD_LAT.
  - `rd_valid` at t+RD_LAT+1 (FIFO output registered).
  - Sustained 1 element/cycle when `rd_ready` is held high.
- **Done:**
  - `done` pulses in the cycle IDLE is re-entered, which is the cycle after the final write handshake or after the pop of the `rd_last` entry.
  - `cmd_ready` returns to 1 in that same cycle.
- **FIFO boundaries:**
  - Push and pop in the same cycle: occupancy unchanged.
  - Pop when full frees a credit, and `re` may assert in the next cycle.
- **Reset mid-command:** immediate return to IDLE, FIFO flushed, no `done`. `matrix_ctrl` must receive reset in the same cycle so its counters stay aligned.

## Structure
- Package `matrix_pkg` holds:
  - `OP_WRITE`/`OP_READ` constants;
  - the state enum (IDLE, WRITE, READ, DRAIN);
  - default `DIM_W`/`DATA_W`.
- Sub-module `matrix_rd_fifo` contains:
  - a synchronous FIFO (DATA_W+1 bits, last tag included) with occupancy output;
  - async active-high reset.
- The top contains the FSM, the 2-D counter mirror, the in-flight shift register and credit logic.

## Test plan
- **Write, small:** rows=1, cols=2, write 0x10..0x15 with `wr_valid` held → 6 `we` pulses with `ram_wdata` 0x10..0x15, `done` one cycle after the 6th, `cmd_ready` high again.
- **Read with backpressure:** preload 0x10..0x15, rows=1, cols=2; `rd_ready` toggles 1,0,1,0… → `rd_data` 0x10..0x15 in order, `rd_last` only with 0x15, FIFO occupancy never >4, `re` count exactly 6.
- **Full stall:** `rd_ready`=0 for 20 cycles on a 64-element read → exactly 4 `re` issued, then `re` low; resume → remaining 60 `re` issued, all 64 words correct.
- **Single element:** rows=cols=0 → one `we` (or one `re` with `rd_last`=1), `done` once, `matrix_ctrl` counters back at (0,0).
- **Reset mid-read:** `RST` pulses after 3 of 6 elements → `busy`=0, `rd_valid`=0, no `done`; a new read returns the element at (0,0) first.
- **Ignored inputs:** `cmd_valid` during WRITE and `wr_valid` during READ → ignored; no extra `we` and no second command.
